// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - byte-stream command front-end for the 8-bit ALU
// Collects opcode/operand bytes, runs one ALU op, accumulates and returns the result.
module alu_sequencer #(
  parameter logic [7:0] ACC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_r,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_RESP
  } state_t;

  state_t     r_state;
  logic [7:0] r_opa;
  logic [7:0] r_opb;
  logic [2:0] r_sel;
  logic       r_unary;
  logic [7:0] r_acc;
  logic [7:0] r_out_data;
  logic       r_out_valid;
  logic       r_in_ready;
  logic       r_busy;

  wire w_use_acc = in_data[3];
  wire w_unary   = in_data[4];

  assign alu_a     = r_opa;
  assign alu_b     = r_opb;
  assign alu_sel   = r_sel;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;

  // in_ready/busy are registered alongside the state transition so they track r_state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opa       <= 8'h00;
      r_opb       <= 8'h00;
      r_sel       <= 3'b000;
      r_unary     <= 1'b0;
      r_acc       <= ACC_INIT;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sel   <= in_data[2:0];
            r_unary <= w_unary;
            r_busy  <= 1'b1;
            if (w_use_acc) r_opa <= r_acc;
            if (w_unary)   r_opb <= 8'h00;
            if (!w_use_acc) begin
              r_state <= S_LOAD_A;
            end else if (!w_unary) begin
              r_state <= S_LOAD_B;
            end else begin
              r_state    <= S_EXEC;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_LOAD_A: begin
          if (in_valid) begin
            r_opa <= in_data;
            if (r_unary) begin
              r_state    <= S_EXEC;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= S_LOAD_B;
            end
          end
        end
        S_LOAD_B: begin
          if (in_valid) begin
            r_opb      <= in_data;
            r_state    <= S_EXEC;
            r_in_ready <= 1'b0;
          end
        end
        S_EXEC: begin
          r_acc       <= alu_r;
          r_out_data  <= alu_r;
          r_out_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
// Includes a behavioural ALU driven by the sequencer's alu_* outputs.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_r;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int n_hs = 0;

  alu_sequencer #(.ACC_INIT(8'h00)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_sel)
      3'd0: alu_r = alu_a + alu_b;
      3'd1: alu_r = alu_a - alu_b;
      3'd2: alu_r = alu_a & alu_b;
      3'd3: alu_r = alu_a | alu_b;
      3'd4: alu_r = {alu_a[6:0], alu_a[7]};
      3'd5: alu_r = {alu_a[0], alu_a[7:1]};
      default: alu_r = 8'h00;
    endcase
  end

  always @(posedge clk) if (!rst && in_valid && in_ready) n_hs++;

  task automatic send_byte(input logic [7:0] b);
    int cnt = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [7:0] d, output logic ok);
    int cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    ok = out_valid;
    d  = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid, out_data, alu_a, alu_b, alu_sel} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000}) begin
      failures++;
      $display("FAIL reset_state: rdy=%b busy=%b ov=%b od=%h a=%h b=%h sel=%h required 1 0 0 00 00 00 0",
               in_ready, busy, out_valid, out_data, alu_a, alu_b, alu_sel);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    logic [7:0] d;
    logic ok;
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL add_exec_cycle: ov=%b busy=%b rdy=%b required 0 1 0", out_valid, busy, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h46) begin
      failures++;
      $display("FAIL add_latency: ov=%b od=%h required 1 46", out_valid, out_data);
    end
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'h46) begin
      failures++;
      $display("FAIL add_result: ok=%b data=%h required 1 46", ok, d);
    end
  endtask

  task automatic test_sub_then_acc_or;
    logic [7:0] d;
    logic ok;
    int hs0;
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h20);
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'hF0) begin
      failures++;
      $display("FAIL sub_wrap: ok=%b data=%h required 1 f0", ok, d);
    end
    hs0 = n_hs;
    send_byte(8'h0B);
    send_byte(8'h0F);
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'hFF) begin
      failures++;
      $display("FAIL or_use_acc: ok=%b data=%h required 1 ff", ok, d);
    end
    checks++;
    if (n_hs - hs0 !== 2) begin
      failures++;
      $display("FAIL or_use_acc_bytes: consumed=%0d required 2", n_hs - hs0);
    end
  endtask

  task automatic test_unary_rotate;
    logic [7:0] d;
    logic ok;
    int hs0;
    send_byte(8'h14);
    send_byte(8'h81);
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'h03 || alu_b !== 8'h00) begin
      failures++;
      $display("FAIL rotl_unary: ok=%b data=%h alu_b=%h required 1 03 00", ok, d, alu_b);
    end
    hs0 = n_hs;
    send_byte(8'h1D);
    checks++;
    if (alu_b !== 8'h00 || alu_a !== 8'h03 || alu_sel !== 3'd5) begin
      failures++;
      $display("FAIL rotr_operands: a=%h b=%h sel=%h required 03 00 5", alu_a, alu_b, alu_sel);
    end
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'h81 || n_hs - hs0 !== 1) begin
      failures++;
      $display("FAIL rotr_acc_unary: ok=%b data=%h bytes=%0d required 1 81 1", ok, d, n_hs - hs0);
    end
  endtask

  task automatic test_reserved;
    logic [7:0] d;
    logic ok;
    send_byte(8'h06);
    send_byte(8'hAA);
    send_byte(8'h55);
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'h00) begin
      failures++;
      $display("FAIL reserved_op: ok=%b data=%h required 1 00", ok, d);
    end
    send_byte(8'h18);
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'h00) begin
      failures++;
      $display("FAIL reserved_acc: ok=%b acc_out=%h required 1 00", ok, d);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] d;
    logic ok;
    int hs0;
    int cnt = 0;
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    hs0 = n_hs;
    in_data  = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h46 || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: ov=%b od=%h rdy=%b busy=%b required 1 46 0 1",
                 i, out_valid, out_data, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_hs !== hs0) begin
      failures++;
      $display("FAIL bp_no_consume: consumed=%0d required 0", n_hs - hs0);
    end
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'h46 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: ok=%b data=%h ov=%b busy=%b rdy=%b required 1 46 0 0 1",
               ok, d, out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_command;
    logic [7:0] d;
    logic ok;
    send_byte(8'h00);
    send_byte(8'h12);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, out_valid, out_data, alu_a, alu_b, alu_sel} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000}) begin
      failures++;
      $display("FAIL async_reset: rdy=%b busy=%b ov=%b od=%h a=%h b=%h sel=%h required 1 0 0 00 00 00 0",
               in_ready, busy, out_valid, out_data, alu_a, alu_b, alu_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h18);
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'h00) begin
      failures++;
      $display("FAIL acc_init: ok=%b acc_out=%h required 1 00", ok, d);
    end
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    get_result(d, ok);
    checks++;
    if (!ok || d !== 8'h02) begin
      failures++;
      $display("FAIL add_after_reset: ok=%b data=%h required 1 02", ok, d);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_then_acc_or;
    test_unary_rotate;
    test_backpressure;
    test_reserved;
    test_reset_mid_command;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command front-end that drives the 8-bit ALU. It accepts a byte stream over a valid/ready handshake: an opcode byte, then up to two operand bytes. It presents the operands and select to the ALU, captures the result into an accumulator, and returns the result over a second valid/ready handshake. It sits between the chip's byte I/O and the ALU instance.

Parameters:
ACC_INIT, 8'h00, reset value of the accumulator register.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
in_data  input  8  command/operand byte.
in_valid  input  1  in_data valid.
in_ready  output  1  sequencer accepts in_data this cycle.
alu_a  output  8  to ALU operand A.
alu_b  output  8  to ALU operand B.
alu_sel  output  3  to ALU operation select.
alu_r  input  8  from ALU result (combinational).
out_data  output  8  result byte.
out_valid  output  1  out_data valid.
out_ready  input  1  consumer accepts out_data.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; opa, opb, sel regs=0; acc=ACC_INIT; out_data=0; out_valid=0; in_ready=1; busy=0; alu_a/alu_b/alu_sel=0. Takes effect immediately, including mid-command; any partial command is discarded.
- Transfer rule: a byte is consumed only on a clk edge with in_valid&in_ready. A result is consumed only on out_valid&out_ready.
- Opcode byte format:
  - [2:0] sel: 000 add, 001 sub, 010 and, 011 or, 100 rotl, 101 rotr, 110/111 reserved; the ALU returns 0 for reserved, and that 0 is returned and stored normally.
  - [3] USE_ACC: A comes from acc; skip LOAD_A.
  - [4] UNARY: B=0; skip LOAD_B.
  - [7:5] ignored.
- alu_a/alu_b/alu_sel are driven directly from the opa/opb/sel registers at all times.
- States:
  - IDLE: in_ready=1. On handshake, latch sel and flags. If USE_ACC, opa<=acc. If UNARY, opb<=0. Next state: LOAD_A if !USE_ACC, else LOAD_B if !UNARY, else EXEC.
  - LOAD_A: in_ready=1. On handshake, opa<=in_data. Next: LOAD_B if !UNARY, else EXEC.
  - LOAD_B: in_ready=1. On handshake, opb<=in_data. Next: EXEC.
  - EXEC: in_ready=0, one cycle. Registers are stable, so alu_r is valid. At the edge: acc<=alu_r, out_data<=alu_r, out_valid<=1. Next: RESP.
  - RESP: in_ready=0, out_valid=1, out_data held stable. When out_ready=1 at an edge: out_valid<=0, next IDLE. Otherwise stay.
- Latency: result is visible (out_valid=1) exactly one cycle after the final input byte's handshake edge, i.e. after the EXEC cycle. A command with both flags set takes 1 cycle from opcode handshake to EXEC.
- No overlap: a new opcode cannot be accepted in the cycle out_valid drops. The earliest next opcode handshake is the first IDLE cycle after the result handshake.
- Arithmetic is mod 256, with no carry/borrow output: sub 0x10-0x20 = 0xF0.
- acc updates only in EXEC. Stalled in_valid holds the FSM in the current load state indefinitely with no timeout.

Test Plan:
- Add: opcode 0x00, A=0x12, B=0x34 -> out_data 0x46 one cycle after the B handshake; acc=0x46.
- Sub wrap: opcode 0x01, A=0x10, B=0x20 -> 0xF0. Then opcode 0x0B (OR, USE_ACC), B=0x0F -> 0xFF, with only two input bytes consumed.
- Unary rotate: opcode 0x14 (rotl, UNARY), A=0x81 -> 0x03. Then opcode 0x1D (rotr, USE_ACC+UNARY) -> 0x81 with one input byte. Check alu_b=0 during both.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid and out_data stable, in_ready=0, and an in_valid byte presented is not consumed. Release -> IDLE next cycle and busy=0.
- Reserved op: opcode 0x06, A=0xAA, B=0x55 -> 0x00; acc=0x00.
- Reset mid-command: assert rst asynchronously (between edges) after the opcode and A bytes -> all outputs at reset values immediately, acc=ACC_INIT. A subsequent full add command 0x00/0x01/0x01 -> 0x02.
